// File: rtl/fg_prog_sequencer.sv
// Floating-gate programming sequencer: latches one command, then walks SETUP/PULSE/GAP/RELEASE/DONE.
// Optional macro FG_PROG_RANGE_CHECK_EN rejects out-of-range row/column commands with an err strobe.
module fg_prog_sequencer #(
    parameter int H_BITS     = 6,
    parameter int V_BITS     = 5,
    parameter int NUM_COLS   = 26,
    parameter int NUM_ROWS   = 5,
    parameter int SETTLE_CYC = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [V_BITS-1:0] cmd_row,
    input  logic [H_BITS-1:0] cmd_col,
    input  logic              cmd_tunnel,
    input  logic [15:0]       cmd_pulse_len,
    input  logic [7:0]        cmd_pulse_cnt,
    input  logic              abort,
    output logic [V_BITS-1:0] dec_v_addr,
    output logic [H_BITS-1:0] dec_h_addr,
    output logic              dec_en,
    output logic              prog,
    output logic              run,
    output logic              vinj_pulse,
    output logic              vtun_en,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, GAP, RELEASE, DONE} state_t;

    localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYC - 1);

    if (SETTLE_CYC < 1 || NUM_ROWS < 1 || NUM_COLS < 1) begin : g_bad_params
        $error("fg_prog_sequencer: SETTLE_CYC, NUM_ROWS and NUM_COLS must be >= 1");
    end

    state_t            state, state_n;
    logic [15:0]       timer, timer_n;
    logic [7:0]        remain, remain_n;
    logic [15:0]       len_q, len_n;
    logic              tunnel_q, tunnel_n;
    logic [V_BITS-1:0] row_n;
    logic [H_BITS-1:0] col_n;
    logic              err_n;
    logic              in_range;
    logic              prog_n;

    // A zero-length pulse still lasts one cycle, so its terminal count is 0.
    function automatic logic [15:0] pulse_load(input logic [15:0] len);
        return (len == 16'd0) ? 16'd0 : len - 16'd1;
    endfunction

`ifdef FG_PROG_RANGE_CHECK_EN
    assign in_range = (32'(cmd_row) < NUM_ROWS) && (32'(cmd_col) < NUM_COLS);
`else
    assign in_range = 1'b1;
`endif

    always_comb begin
        state_n  = state;
        timer_n  = timer;
        remain_n = remain;
        len_n    = len_q;
        tunnel_n = tunnel_q;
        row_n    = dec_v_addr;
        col_n    = dec_h_addr;
        err_n    = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (in_range) begin
                        state_n  = SETUP;
                        timer_n  = SETTLE_LOAD;
                        remain_n = cmd_pulse_cnt;
                        len_n    = cmd_pulse_len;
                        tunnel_n = cmd_tunnel;
                        row_n    = cmd_row;
                        col_n    = cmd_col;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            SETUP: begin
                if (abort) begin
                    state_n = RELEASE;
                    timer_n = SETTLE_LOAD;
                end else if (timer == 16'd0) begin
                    if (remain == 8'd0) begin
                        state_n = RELEASE;
                        timer_n = SETTLE_LOAD;
                    end else begin
                        state_n = PULSE;
                        timer_n = pulse_load(len_q);
                    end
                end else begin
                    timer_n = timer - 16'd1;
                end
            end
            PULSE: begin
                if (abort) begin
                    state_n = RELEASE;
                    timer_n = SETTLE_LOAD;
                end else if (timer == 16'd0) begin
                    remain_n = remain - 8'd1;
                    state_n  = (remain == 8'd1) ? RELEASE : GAP;
                    timer_n  = SETTLE_LOAD;
                end else begin
                    timer_n = timer - 16'd1;
                end
            end
            GAP: begin
                if (abort) begin
                    state_n = RELEASE;
                    timer_n = SETTLE_LOAD;
                end else if (timer == 16'd0) begin
                    state_n = PULSE;
                    timer_n = pulse_load(len_q);
                end else begin
                    timer_n = timer - 16'd1;
                end
            end
            RELEASE: begin
                if (timer == 16'd0) state_n = DONE;
                else                timer_n = timer - 16'd1;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign prog_n = (state_n == SETUP) || (state_n == PULSE) ||
                    (state_n == GAP)   || (state_n == RELEASE);

    // Outputs are registered from the next-state decode so they align with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
            dec_en     <= 1'b0;
            prog       <= 1'b0;
            run        <= 1'b1;
            vinj_pulse <= 1'b0;
            vtun_en    <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            dec_v_addr <= '0;
            dec_h_addr <= '0;
        end else begin
            state      <= state_n;
            cmd_ready  <= (state_n == IDLE);
            busy       <= (state_n != IDLE);
            dec_en     <= (state_n == SETUP) || (state_n == PULSE) || (state_n == GAP);
            prog       <= prog_n;
            run        <= ~prog_n;
            vinj_pulse <= (state_n == PULSE) && !tunnel_n;
            vtun_en    <= (state_n == PULSE) && tunnel_n;
            done       <= (state_n == DONE);
            err        <= err_n;
            dec_v_addr <= row_n;
            dec_h_addr <= col_n;
        end
    end

    // Timing counters and latched command fields are always reloaded on accept, so they need no reset.
    always_ff @(posedge clk) begin
        timer    <= timer_n;
        remain   <= remain_n;
        len_q    <= len_n;
        tunnel_q <= tunnel_n;
    end

endmodule

// File: tb/tb_fg_prog_sequencer.sv
// Directed bench for fg_prog_sequencer: timeline model per command plus literal spot checks.
// Honours FG_PROG_RANGE_CHECK_EN the same way as the design.
module tb_fg_prog_sequencer;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [4:0]  cmd_row = '0;
    logic [5:0]  cmd_col = '0;
    logic        cmd_tunnel = 1'b0;
    logic [15:0] cmd_pulse_len = '0;
    logic [7:0]  cmd_pulse_cnt = '0;
    logic        abort = 1'b0;
    logic [4:0]  dec_v_addr;
    logic [5:0]  dec_h_addr;
    logic        dec_en, prog, run, vinj_pulse, vtun_en, busy, done, err;

    fg_prog_sequencer #(
        .H_BITS(6), .V_BITS(5), .NUM_COLS(26), .NUM_ROWS(5), .SETTLE_CYC(S)
    ) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_tunnel(cmd_tunnel),
        .cmd_pulse_len(cmd_pulse_len), .cmd_pulse_cnt(cmd_pulse_cnt), .abort(abort),
        .dec_v_addr(dec_v_addr), .dec_h_addr(dec_h_addr), .dec_en(dec_en),
        .prog(prog), .run(run), .vinj_pulse(vinj_pulse), .vtun_en(vtun_en),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Model of the command currently in flight, expressed as a timeline relative to acceptance.
    int         t_acc = 0;
    bit         m_active = 1'b0;
    bit         m_rej = 1'b0;
    bit         m_tun = 1'b0;
    int         m_n = 0;
    int         m_l = 1;
    int         ab_k = -1;
    int         rs_k = -1;
    logic [4:0] prev_row = '0, cur_row = '0;
    logic [5:0] prev_col = '0, cur_col = '0;
    bit         chk_en = 1'b0;

    logic [19:0] dut_vec;
    assign dut_vec = {cmd_ready, busy, prog, run, dec_en, vinj_pulse, vtun_en, done, err,
                      dec_v_addr, dec_h_addr};

    task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc - t_acc, act, exp);
        end
    endtask

    // Phase codes: 0 idle, 1 setup, 2 pulse, 3 gap, 4 release, 5 done.
    function automatic logic [19:0] model_vec(input int c);
        int k, r_start, ph, st;
        logic [4:0] r;
        logic [5:0] col;
        bit e;
        k = c - t_acc;
        ph = 0; r = cur_row; col = cur_col; e = 1'b0;
        if (!m_active) begin
            ph = 0;
        end else if (k <= 0) begin
            r = prev_row; col = prev_col;
        end else if (rs_k >= 0 && k > rs_k) begin
            r = '0; col = '0;
        end else if (m_rej) begin
            r = prev_row; col = prev_col; e = (k == 1);
        end else if (ab_k >= 0 && k > ab_k) begin
            if (k <= ab_k + S)          ph = 4;
            else if (k == ab_k + S + 1) ph = 5;
        end else begin
            r_start = 1 + S + m_n * m_l + ((m_n > 0) ? (m_n - 1) : 0) * S;
            if (k <= S) ph = 1;
            else if (k < r_start) begin
                st = (k - 1 - S) % (m_l + S);
                ph = (st < m_l) ? 2 : 3;
            end
            else if (k < r_start + S)  ph = 4;
            else if (k == r_start + S) ph = 5;
        end
        return {ph == 0, ph != 0, (ph >= 1 && ph <= 4), !(ph >= 1 && ph <= 4),
                (ph >= 1 && ph <= 3), (ph == 2 && !m_tun), (ph == 2 && m_tun), ph == 5, e, r, col};
    endfunction

    always @(negedge clk) begin
        if (chk_en) chk("outputs", dut_vec, model_vec(cyc));
    end

    task automatic issue(input logic [4:0] row, input logic [5:0] col, input logic tun,
                         input logic [15:0] len, input logic [7:0] cnt);
        bit rej;
        @(posedge clk); #1;
`ifdef FG_PROG_RANGE_CHECK_EN
        rej = (row >= 5) || (col >= 26);
`else
        rej = 1'b0;
`endif
        t_acc = cyc; m_active = 1'b1; m_rej = rej; ab_k = -1; rs_k = -1;
        m_tun = tun; m_n = int'(cnt); m_l = (len == 16'd0) ? 1 : int'(len);
        prev_row = cur_row; prev_col = cur_col;
        if (!rej) begin cur_row = row; cur_col = col; end
        cmd_row = row; cmd_col = col; cmd_tunnel = tun;
        cmd_pulse_len = len; cmd_pulse_cnt = cnt; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic at_k(input int k);
        int guard = 0;
        while (cyc - t_acc < k && guard < 1000) begin
            @(posedge clk); #1;
            guard++;
        end
    endtask

    task automatic peek(input int k);
        at_k(k);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", {19'b0, cmd_ready}, 20'd1);
        chk("reset_run", {19'b0, run}, 20'd1);
        chk("reset_vec", dut_vec, 20'h90000);
        @(posedge clk); #1;
        reset = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);

        // Inject, row 2 col 10, L=10 N=3; a stray cmd_valid while busy must be ignored.
        issue(5'd2, 6'd10, 1'b0, 16'd10, 8'd3);
        peek(4);  chk("inj_k4_vinj", {19'b0, vinj_pulse}, 20'd0);
        peek(5);  chk("inj_k5_vinj", {19'b0, vinj_pulse}, 20'd1);
        at_k(10); cmd_valid = 1'b1; cmd_row = 5'd7; cmd_col = 6'd1;
        at_k(11); cmd_valid = 1'b0;
        peek(14); chk("inj_k14_vinj", {19'b0, vinj_pulse}, 20'd1);
        peek(15); chk("inj_k15_vinj", {19'b0, vinj_pulse}, 20'd0);
        peek(42); chk("inj_k42_den", {19'b0, dec_en}, 20'd1);
        peek(43); chk("inj_k43_den", {19'b0, dec_en}, 20'd0);
        peek(46); chk("inj_k46_prog", {19'b0, prog}, 20'd1);
        peek(47); chk("inj_k47_done", {18'b0, done, prog}, 20'd2);
        peek(48); chk("inj_k48_ready", {19'b0, cmd_ready}, 20'd1);

        // Tunnel with zero pulses.
        issue(5'd1, 6'd3, 1'b1, 16'd5, 8'd0);
        peek(4);  chk("n0_k4_den", {19'b0, dec_en}, 20'd1);
        peek(5);  chk("n0_k5_den_vtun", {18'b0, dec_en, vtun_en}, 20'd0);
        peek(9);  chk("n0_k9_done", {19'b0, done}, 20'd1);
        at_k(10);

        // Tunnel with zero pulse length, two pulses.
        issue(5'd0, 6'd5, 1'b1, 16'd0, 8'd2);
        peek(5);  chk("l0_k5_pulses", {18'b0, vinj_pulse, vtun_en}, 20'd1);
        peek(6);  chk("l0_k6_vtun", {19'b0, vtun_en}, 20'd0);
        peek(10); chk("l0_k10_pulses", {18'b0, vinj_pulse, vtun_en}, 20'd1);
        peek(11); chk("l0_k11_vtun", {19'b0, vtun_en}, 20'd0);
        peek(15); chk("l0_k15_done", {19'b0, done}, 20'd1);
        at_k(16);

        // Abort in the second pulse of an N=5 command; abort in RELEASE is a no-op.
        issue(5'd4, 6'd25, 1'b0, 16'd6, 8'd5);
        at_k(17); abort = 1'b1; ab_k = 17;
        @(negedge clk); chk("ab_k17_vinj", {19'b0, vinj_pulse}, 20'd1);
        at_k(18); abort = 1'b0;
        @(negedge clk); chk("ab_k18_state", {17'b0, vinj_pulse, prog, dec_en}, 20'd2);
        at_k(20); abort = 1'b1;
        at_k(21); abort = 1'b0;
        @(negedge clk); chk("ab_k21_prog", {19'b0, prog}, 20'd1);
        peek(22); chk("ab_k22_done", {19'b0, done}, 20'd1);

        // Out-of-range column, issued back-to-back at the first idle cycle.
        issue(5'd0, 6'd26, 1'b0, 16'd2, 8'd1);
        @(negedge clk);
`ifdef FG_PROG_RANGE_CHECK_EN
        chk("rng_k1_err", {18'b0, err, busy}, 20'd2);
        chk("rng_k1_haddr", {14'b0, dec_h_addr}, 20'd25);
        peek(2);  chk("rng_k2_err", {19'b0, err}, 20'd0);
        at_k(4);
`else
        chk("rng_k1_haddr", {14'b0, dec_h_addr}, 20'd26);
        chk("rng_k1_busy_err", {18'b0, busy, err}, 20'd2);
        peek(11); chk("rng_k11_done", {19'b0, done}, 20'd1);
        at_k(12);
`endif

        // Reset during PULSE: immediate return to reset values, no done.
        issue(5'd3, 6'd7, 1'b0, 16'd8, 8'd2);
        at_k(7); reset = 1'b1; rs_k = 7;
        @(negedge clk); chk("rst_k7_vinj", {19'b0, vinj_pulse}, 20'd1);
        peek(8); chk("rst_k8_vec", dut_vec, 20'h90000);
        at_k(9); reset = 1'b0;
        peek(25); chk("rst_k25_ready", {18'b0, cmd_ready, done}, 20'd2);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
